// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT control with
// a program counter, one-level interrupt entry and reti support.
module instruction_sequencer #(
  parameter logic [26:0] RESET_PC   = 27'd0,
  parameter logic [26:0] INT_VECTOR = 27'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  instrOP,
  input  logic        jump_valid,
  input  logic [26:0] jump_addr,
  input  logic        bus_done,
  input  logic        int_req,
  output logic        bus_start,
  output logic        bus_we,
  output logic [26:0] bus_addr,
  input  logic [26:0] data_addr,
  output logic        fetch,
  output logic        getRegs,
  output logic        exec,
  output logic        writeback,
  output logic [26:0] pc,
  output logic        int_ack,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hD;
  localparam logic [3:0] OP_RETI  = 4'hC;

  state_e      state_q;
  logic [26:0] pc_q;
  logic [26:0] retPc_q;
  logic        intEn_q;
  logic        first_q;
  logic        busy_q;
  logic        isStore_q;
  logic [26:0] busAddr_q;
  logic        busWe_q;
  logic        getRegs_q;
  logic        exec_q;
  logic        wb_q;
  logic        halted_q;
  logic [26:0] pcExec_d;
  logic        intTake;

  // reti restores the saved PC and takes priority over any jump request.
  always_comb begin
    pcExec_d = jump_valid ? jump_addr : pc_q + 27'd1;
    if (instrOP == OP_RETI) begin
      pcExec_d = retPc_q;
    end
  end

  assign intTake = int_req & intEn_q;

  // A transfer only counts bus_done once busy_q is set, so stale completions are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      retPc_q   <= 27'd0;
      intEn_q   <= 1'b1;
      first_q   <= 1'b1;
      busy_q    <= 1'b0;
      isStore_q <= 1'b0;
      busAddr_q <= RESET_PC;
      busWe_q   <= 1'b0;
      getRegs_q <= 1'b0;
      exec_q    <= 1'b0;
      wb_q      <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      first_q   <= 1'b0;
      getRegs_q <= 1'b0;
      exec_q    <= 1'b0;
      wb_q      <= 1'b0;
      case (state_q)
        FETCH: begin
          if (first_q) begin
            busy_q <= 1'b1;
          end else if (busy_q && bus_done) begin
            busy_q    <= 1'b0;
            state_q   <= DECODE;
            getRegs_q <= 1'b1;
          end
        end
        DECODE: begin
          state_q <= EXEC;
          exec_q  <= 1'b1;
        end
        EXEC: begin
          pc_q <= pcExec_d;
          if (instrOP == OP_RETI) begin
            intEn_q <= 1'b1;
          end
          if (instrOP == OP_HALT) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (instrOP == OP_LOAD || instrOP == OP_STORE) begin
            state_q   <= MEM;
            first_q   <= 1'b1;
            busAddr_q <= data_addr;
            busWe_q   <= (instrOP == OP_STORE);
            isStore_q <= (instrOP == OP_STORE);
          end else begin
            state_q   <= WB;
            wb_q      <= 1'b1;
            isStore_q <= 1'b0;
          end
        end
        MEM: begin
          if (first_q) begin
            busy_q <= 1'b1;
          end else if (busy_q && bus_done) begin
            busy_q  <= 1'b0;
            busWe_q <= 1'b0;
            state_q <= WB;
            wb_q    <= ~isStore_q;
          end
        end
        WB: begin
          state_q <= FETCH;
          first_q <= 1'b1;
          if (intTake) begin
            retPc_q   <= pc_q;
            pc_q      <= INT_VECTOR;
            intEn_q   <= 1'b0;
            busAddr_q <= INT_VECTOR;
          end else begin
            busAddr_q <= pc_q;
          end
        end
        HALT: begin
          if (intTake) begin
            retPc_q   <= pc_q;
            pc_q      <= INT_VECTOR;
            intEn_q   <= 1'b0;
            busAddr_q <= INT_VECTOR;
            state_q   <= FETCH;
            first_q   <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= FETCH;
          first_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_start = first_q & ~reset;
  assign bus_we    = busWe_q;
  assign bus_addr  = busAddr_q;
  assign fetch     = (state_q == FETCH) & busy_q & bus_done & ~reset;
  assign getRegs   = getRegs_q;
  assign exec      = exec_q;
  assign writeback = wb_q;
  assign pc        = pc_q;
  assign int_ack   = ((state_q == WB) | (state_q == HALT)) & intTake & ~reset;
  assign halted    = halted_q;

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 27'd0: address of the first fetch after reset.
REQ-003 Parameter INT_VECTOR, default 27'd1: address fetched on interrupt entry.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: synchronous reset, active-high.
- instrOP, in, 4: opcode field from the instruction decoder.
- jump_valid, in, 1: execute stage requests a PC load; sampled in EXEC.
- jump_addr, in, 27: target for that PC load.
- bus_done, in, 1: memory bus transfer complete; one-cycle pulse.
- int_req, in, 1: level interrupt request.
- bus_start, out, 1: one-cycle bus request pulse.
- bus_we, out, 1: write request, qualified by bus_start.
- bus_addr, out, 27: fetch address or data address.
- data_addr, in, 27: data address for memory instructions.
- fetch, out, 1: decoder latch strobe.
- getRegs, out, 1: register-file read strobe.
- exec, out, 1: execute strobe.
- writeback, out, 1: register write strobe.
- pc, out, 27: current program counter.
- int_ack, out, 1: interrupt-entry pulse.
- halted, out, 1: sequencer stopped.

Function
REQ-005 The block SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-006 FETCH SHALL behave as follows:
- bus_start=1 and bus_addr=pc in the first FETCH cycle only, with bus_we=0.
- The block stays in FETCH until bus_done.
- fetch SHALL be 1 in exactly the cycle where bus_done=1 while in FETCH.
- The next state is DECODE.
REQ-007 DECODE SHALL assert getRegs for one cycle and then go to EXEC.
REQ-008 EXEC SHALL assert exec for one cycle and then select the next state:
- instrOP==4'hF: go to HALT.
- instrOP==4'hE (load) or 4'hD (store): go to MEM.
- Any other instrOP: go to WB.
REQ-009 MEM SHALL behave as follows:
- In the first MEM cycle, drive a bus_start pulse with bus_addr=data_addr.
- bus_we=1 for a store and 0 for a load.
- Wait for bus_done, then go to WB.
REQ-010 WB SHALL assert writeback for one cycle, except that writeback SHALL be 0 for a store; the next state is FETCH.
REQ-011 PC update SHALL occur on the EXEC cycle:
- If jump_valid=1, pc <= jump_addr.
- Otherwise pc <= pc+1, wrapping from 27'h7FFFFFF to 0.
REQ-012 Interrupt entry SHALL be evaluated in the WB cycle:
- Condition: int_req=1 and int_en=1 (int_en is an internal flag).
- Action: ret_pc <= pc (the already-updated value), pc <= INT_VECTOR, int_en <= 0, and int_ack=1 for that cycle.
REQ-013 instrOP==4'hC (reti) SHALL be handled in EXEC:
- pc <= ret_pc and int_en <= 1, overriding jump_valid.
- The next state is WB.
REQ-014 HALT SHALL behave as follows:
- halted=1; all strobes and bus_start are 0.
- The state is left only on reset, or on int_req=1 with int_en=1.
- On that interrupt, perform the interrupt entry of REQ-012 with ret_pc <= pc, then go to FETCH.
REQ-015 At most one of fetch, getRegs, exec and writeback SHALL be 1 in any cycle.
REQ-016 bus_done received outside FETCH or MEM, or after the first bus_done of a transfer, SHALL be ignored.
REQ-017 bus_start SHALL never be reasserted while a transfer is pending.

Reset
REQ-018 When reset=1, the block SHALL enter FETCH with the following values:
- pc=RESET_PC, ret_pc=0, int_en=1.
- All outputs are 0 except bus_addr=RESET_PC.
- No bus_start pulse occurs in the reset cycle.
REQ-019 The first cycle after reset deasserts SHALL be a first FETCH cycle, with bus_start=1.
REQ-020 Reset asserted mid-transfer (in FETCH or MEM) SHALL abandon the transfer, and a late bus_done after reset SHALL NOT produce fetch.

Verification
REQ-021 Reset, then bus_done 2 cycles after bus_start, with instrOP=4'h0 and jump_valid=0:
- Expect fetch in the bus_done cycle, then getRegs, exec and writeback on consecutive cycles.
- Expect pc=1 after EXEC and a new bus_start with bus_addr=1.
REQ-022 Load at pc=5 with data_addr=27'h100 and bus_done delayed 4 cycles:
- Expect a MEM bus_start with bus_we=0 and bus_addr=27'h100.
- Expect writeback one cycle after bus_done and pc=6.
- Repeat with a store: expect bus_we=1 and no writeback.
REQ-023 EXEC with jump_valid=1 and jump_addr=27'h1234: expect the next fetch bus_addr=27'h1234.
REQ-024 At pc=27'h7FFFFFF with no jump: expect the next fetch at address 0.
REQ-025 Interrupt entry and return:
- Hold int_req=1 during an ALU instruction at pc=10: expect int_ack in WB and the next fetch at 1.
- Expect no second int_ack while int_en=0.
- A subsequent reti: expect the fetch address to be 11.
REQ-026 Halt and reset:
- instrOP=4'hF: expect halted=1 and no strobes over 20 cycles; int_req then resumes fetch at INT_VECTOR.
- Reset asserted during a FETCH wait with bus_done one cycle after reset: expect no fetch pulse and pc=RESET_PC.
